load_store_unit: RTL and testbench

//  Sits between the RV32I execute stage and the byte-addressed data memory (op/rw/addr/data_w/data_r port).

---
 rtl/load_store_unit_pkg.sv | 34 +++
 rtl/lsu_lane_align.sv | 36 +++
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - funct3 codes, FSM states and request legality helpers for the load/store unit
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Unsigned extensions exist only for loads; stores accept b/h/w.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lsb);
    case (f3)
      F3_H, F3_HU: return lsb[0];
      F3_W:        return |lsb;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - load sign/zero extension and sub-word store merge, selected by funct3
module lsu_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merge_data
);

  // Memory returns the four bytes starting at the request address, so lanes are always the low bits.
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{(DATA_WIDTH-8){mem_rdata[7]}}, mem_rdata[7:0]};
      F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, mem_rdata[7:0]};
      F3_H:    load_data = {{(DATA_WIDTH-16){mem_rdata[15]}}, mem_rdata[15:0]};
      F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, mem_rdata[15:0]};
      F3_W:    load_data = mem_rdata;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    merge_data = store_data;
    case (funct3)
      F3_B:    merge_data = {mem_rdata[DATA_WIDTH-1:8], store_data[7:0]};
      F3_H:    merge_data = {mem_rdata[DATA_WIDTH-1:16], store_data[15:0]};
      default: merge_data = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store sequencer: request checks, RMW for sub-word stores, memory port drive
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_op,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic [DATA_WIDTH-1:0] mem_data_r
);

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MEM_SIZE - 4);

  lsu_state_e            state_q, state_d;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  req_bad;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;

  // Every access touches four bytes, so even byte accesses must leave room for a full word.
  assign accept  = req_valid && (state_q == ST_IDLE);
  assign req_bad = !f3_legal(req_we, req_funct3) || (req_addr > MAX_ADDR)
                   || misaligned(req_funct3, req_addr[1:0]);

  lsu_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .funct3     (f3_q),
    .mem_rdata  (mem_data_r),
    .store_data (data_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory outputs come from state and registers only: memory samples them on negedge.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_op     = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = '0;
    mem_data_w = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_bad) begin
            state_d = ST_RESP;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        mem_op   = 1'b1;
        mem_addr = addr_q;
        state_d  = we_q ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        mem_op     = 1'b1;
        mem_rw     = 1'b1;
        mem_addr   = addr_q;
        mem_data_w = data_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sub-word stores reuse data_q: it holds wdata on accept and the merged word after the read.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= F3_B;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      data_q  <= req_wdata;
      rdata_q <= '0;
      err_q   <= req_bad;
    end else if (state_q == ST_RD) begin
      if (we_q) begin
        data_q <= merge_data;
      end else begin
        rdata_q <= load_data;
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with negedge memory and reference model
module tb_load_store_unit;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_op;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_w;
  logic [31:0] mem_data_r;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:1023];
  logic [7:0]  ref_mem [0:1023];
  bit          mem_loaded = 1'b0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  load_store_unit dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_op     (mem_op),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_data_w (mem_data_w),
    .mem_data_r (mem_data_r)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Byte-addressed memory: four bytes from addr, little-endian, acted on at negedge of an op cycle.
  always @(negedge sys_clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[0] = 8'hB3; mem[1] = 8'h00; mem[2] = 8'h31; mem[3] = 8'h00;
      mem_loaded = 1'b1;
    end
    if (mem_op) begin
      if (mem_rw) begin
        n_wr++;
        last_wa = mem_addr;
        last_wd = mem_data_w;
        if (mem_addr <= 32'd1020)
          for (int i = 0; i < 4; i++) mem[mem_addr + i] = mem_data_w[8*i +: 8];
      end else begin
        n_rd++;
        if (mem_addr <= 32'd1020)
          mem_data_r <= {mem[mem_addr+3], mem[mem_addr+2], mem[mem_addr+1], mem[mem_addr]};
        else
          mem_data_r <= 32'hDEADBEEF;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural outcome of one request, straight from the RV32I rules.
  task automatic ref_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output bit err, output logic [31:0] rd,
                            output int lat, output int nr, output int nw);
    int size;
    bit legal;
    logic [31:0] w;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err   = !legal || (a > 32'd1020) || ((a % size) != 0);
    rd = '0; lat = 1; nr = 0; nw = 0;
    if (!err) begin
      if (!we) begin
        w = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        case (f3)
          3'd0: rd = $signed(w[7:0]);
          3'd4: rd = {24'd0, w[7:0]};
          3'd1: rd = $signed(w[15:0]);
          3'd5: rd = {16'd0, w[15:0]};
          default: rd = w;
        endcase
        lat = 2; nr = 1;
      end else begin
        for (int i = 0; i < size; i++) ref_mem[a+i] = wd[8*i +: 8];
        lat = (size == 4) ? 2 : 3;
        nr  = (size == 4) ? 0 : 1;
        nw  = 1;
      end
    end
  endtask

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag, output logic [31:0] rd_o);
    bit e_err;
    logic [31:0] e_rd;
    int e_lat, e_nr, e_nw, r0, w0, lat;
    bit got;
    logic err_o;
    ref_access(we, f3, a, wd, e_err, e_rd, e_lat, e_nr, e_nw);
    @(posedge sys_clk); #1;
    chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, " idle_resp"}, {31'd0, resp_valid}, 32'd0);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    r0 = n_rd; w0 = n_wr;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    got = 1'b0; lat = 0; rd_o = '0; err_o = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (!got) begin
        if (resp_valid) begin
          got = 1'b1; lat = c; rd_o = resp_rdata; err_o = resp_err;
        end else begin
          @(posedge sys_clk); #1;
        end
      end
    end
    chk({tag, " resp_seen"}, {31'd0, got}, 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " err"}, {31'd0, err_o}, {31'd0, e_err});
    chk({tag, " rdata"}, rd_o, e_rd);
    chk({tag, " mem_reads"}, 32'(n_rd - r0), 32'(e_nr));
    chk({tag, " mem_writes"}, 32'(n_wr - w0), 32'(e_nw));
  endtask

  logic [31:0] rd;
  logic [31:0] exp_q [$];
  logic [31:0] b2b_addr [3];
  int acc, rsp, last_acc, w0, mism;
  bit rv_seen;
  bit rw;
  logic [2:0] rf3;
  logic [31:0] ra;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    ref_mem[0] = 8'hB3; ref_mem[2] = 8'h31;
    sys_rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst mem_op", {31'd0, mem_op}, 32'd0);
    chk("rst mem_rw", {31'd0, mem_rw}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_data_w", mem_data_w, 32'd0);
    sys_rst_n = 1'b1;

    do_req(1'b0, 3'd2, 32'd0, 32'd0, "lw0", rd);
    chk("lw0 const", rd, 32'h003100B3);
    do_req(1'b0, 3'd0, 32'd0, 32'd0, "lb0", rd);
    chk("lb0 const", rd, 32'hFFFFFFB3);
    do_req(1'b0, 3'd4, 32'd0, 32'd0, "lbu0", rd);
    chk("lbu0 const", rd, 32'h000000B3);
    do_req(1'b0, 3'd1, 32'd2, 32'd0, "lh2", rd);
    chk("lh2 const", rd, 32'h00000031);
    do_req(1'b0, 3'd5, 32'd0, 32'd0, "lhu0", rd);
    chk("lhu0 const", rd, 32'h000000B3);

    do_req(1'b1, 3'd0, 32'd1, 32'h12345678, "sb1", rd);
    chk("sb1 write_addr", last_wa, 32'd1);
    chk("sb1 write_data", last_wd, 32'h00003178);
    do_req(1'b0, 3'd2, 32'd0, 32'd0, "lw0 after sb", rd);
    chk("lw0 after sb const", rd, 32'h003178B3);

    do_req(1'b0, 3'd2, 32'd2, 32'd0, "lw2 misaligned", rd);
    do_req(1'b1, 3'd1, 32'd3, 32'h0000BEEF, "sh3 misaligned", rd);
    do_req(1'b0, 3'd3, 32'd0, 32'd0, "funct3 011", rd);
    do_req(1'b1, 3'd4, 32'd0, 32'd0, "store funct3 100", rd);
    do_req(1'b0, 3'd2, 32'd1024, 32'd0, "lw1024", rd);
    do_req(1'b0, 3'd0, 32'd1021, 32'd0, "lb1021", rd);
    do_req(1'b0, 3'd2, 32'd1020, 32'd0, "lw1020", rd);

    // Reset while the sh write cycle is on the memory port; the store must not land.
    @(posedge sys_clk); #1;
    chk("abort ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'd4; req_wdata = 32'h0000BEEF;
    w0 = n_wr;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    chk("abort rd op", {30'd0, mem_op, mem_rw}, 32'd2);
    @(posedge sys_clk); #1;
    chk("abort wr op", {30'd0, mem_op, mem_rw}, 32'd3);
    sys_rst_n = 1'b0;
    #1;
    chk("abort op dropped", {31'd0, mem_op}, 32'd0);
    rv_seen = resp_valid;
    repeat (3) begin
      @(posedge sys_clk); #1;
      rv_seen = rv_seen | resp_valid;
    end
    sys_rst_n = 1'b1;
    #1;
    chk("abort no resp", {31'd0, rv_seen}, 32'd0);
    chk("abort no write", 32'(n_wr - w0), 32'd0);
    chk("abort ready after", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 3'd2, 32'd4, 32'd0, "lw4 after abort", rd);
    chk("lw4 const", rd, 32'h00000000);

    // req_valid held high across three loads.
    b2b_addr[0] = 32'd0; b2b_addr[1] = 32'd4; b2b_addr[2] = 32'd8;
    acc = 0; rsp = 0; last_acc = -1;
    @(posedge sys_clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = b2b_addr[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (rsp < 3) begin
        if (resp_valid) begin
          chk($sformatf("b2b resp%0d", rsp), resp_rdata, exp_q.pop_front());
          rsp++;
        end
        if (req_valid && req_ready) begin
          bit e; logic [31:0] r; int l, nr, nw;
          ref_access(1'b0, 3'd2, req_addr, 32'd0, e, r, l, nr, nw);
          exp_q.push_back(r);
          if (acc > 0) chk($sformatf("b2b spacing%0d", acc), 32'(cyc - last_acc), 32'd3);
          last_acc = cyc;
          acc++;
          @(posedge sys_clk); #1;
          if (acc < 3) req_addr = b2b_addr[acc];
          else req_valid = 1'b0;
        end else begin
          @(posedge sys_clk); #1;
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b accepts", 32'(acc), 32'd3);
    chk("b2b responses", 32'(rsp), 32'd3);

    for (int i = 0; i < 60; i++) begin
      int mode;
      rw  = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 9);
      if (mode == 0) ra = $urandom();
      else if (mode == 1) ra = 32'd1016 + $urandom_range(0, 12);
      else ra = $urandom_range(0, 40);
      do_req(rw, rf3, ra, $urandom(), $sformatf("rnd%0d", i), rd);
    end

    @(posedge sys_clk); #1;
    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("final mem image mismatching bytes", 32'(mism), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
